// File: rtl/m_mem_access.sv
// m_mem_access - M-stage data-memory access controller.
//
// Turns the decoded M-stage load/store into a req/ack transaction on the
// data bus and stalls the pipeline until the bus answers. Load data is lane
// selected and sign/zero extended into dr_out for the M/W register.
// Misaligned accesses never reach the bus; they are reported as AdEL/AdES.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   -> a REQ that sees no bus_ack for TIMEOUT_CYCLES cycles is
//                abandoned; DONE reports exc_code 7 and dr_out = 0.
//   undefined -> REQ waits for bus_ack indefinitely.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   valid, flush        M-stage instruction qualifiers
//   mem_op[3:0]         0 none,1 LW,2 LH,3 LHU,4 LB,5 LBU,6 SW,7 SH,8 SB
//   addr, store_data    effective byte address, rt value
//   bus_req/we/addr/wdata/byteen  registered bus request
//   bus_ack, bus_rdata  bus completion and read word
//   stall               combinational pipeline freeze
//   dr_out              registered extended load result
//   done                1-cycle pulse in the DONE state
//   exc_code[4:0]       4 AdEL, 5 AdES, 7 bus error, 0 none

module m_mem_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        flush,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic [31:0] dr_out,
    output logic        done,
    output logic [4:0]  exc_code
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      state;
    logic [3:0]  lat_op;     // op and lane latched at start; inputs may move
    logic [1:0]  lat_lane;

    logic        op_is_mem, op_is_load, op_is_store, misaligned, start;
    logic [3:0]  st_byteen;
    logic [31:0] st_wdata;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;
    logic        lat_is_load;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] to_cnt;
    logic          to_flag;  // current DONE was reached by timeout
`endif

    // ---------------- decode ----------------
    always_comb begin
        op_is_mem   = (mem_op >= OP_LW) && (mem_op <= OP_SB);
        op_is_load  = (mem_op >= OP_LW) && (mem_op <= OP_LBU);
        op_is_store = (mem_op >= OP_SW) && (mem_op <= OP_SB);
        misaligned  = 1'b0;
        case (mem_op)
            OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
            default:              misaligned = 1'b0;
        endcase
        start = valid & ~flush & op_is_mem & ~misaligned;
        stall = ((state == S_IDLE) & start) | (state == S_REQ);
    end

    // ---------------- store lane steering ----------------
    always_comb begin
        st_byteen = 4'b1111;
        st_wdata  = store_data;
        case (mem_op)
            OP_SH: begin
                st_byteen = 4'b0011 << addr[1:0];
                st_wdata  = {2{store_data[15:0]}};
            end
            OP_SB: begin
                st_byteen = 4'b0001 << addr[1:0];
                st_wdata  = {4{store_data[7:0]}};
            end
            default: ;
        endcase
    end

    // ---------------- load alignment / extension ----------------
    always_comb begin
        lat_is_load = (lat_op >= OP_LW) && (lat_op <= OP_LBU);
        ld_b        = bus_rdata[{lat_lane, 3'b000} +: 8];
        ld_h        = lat_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lat_op)
            OP_LB:   ld_data = {{24{ld_b[7]}}, ld_b};
            OP_LBU:  ld_data = {24'd0, ld_b};
            OP_LH:   ld_data = {{16{ld_h[15]}}, ld_h};
            OP_LHU:  ld_data = {16'd0, ld_h};
            default: ld_data = bus_rdata;
        endcase
    end

    // ---------------- exceptions ----------------
    always_comb begin
        exc_code = 5'd0;
        if (valid & ~flush & op_is_mem & misaligned)
            exc_code = op_is_load ? 5'd4 : 5'd5;
`ifdef MEM_TIMEOUT_EN
        if ((state == S_DONE) && to_flag)
            exc_code = 5'd7;
`endif
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            lat_op     <= 4'd0;
            lat_lane   <= 2'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            bus_byteen <= 4'd0;
            dr_out     <= 32'd0;
            done       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            to_cnt     <= '0;
            to_flag    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_REQ;
                        lat_op     <= mem_op;
                        lat_lane   <= addr[1:0];
                        bus_req    <= 1'b1;
                        bus_we     <= op_is_store;
                        bus_addr   <= {addr[31:2], 2'b00};
                        bus_wdata  <= op_is_store ? st_wdata : 32'd0;
                        bus_byteen <= op_is_store ? st_byteen : 4'b1111;
`ifdef MEM_TIMEOUT_EN
                        to_cnt     <= '0;
                        to_flag    <= 1'b0;
`endif
                    end
                end
                S_REQ: begin
                    // flush is deliberately ignored here: the bus cannot abort
                    if (bus_ack) begin
                        state   <= S_DONE;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        if (lat_is_load)
                            dr_out <= ld_data;
                    end
`ifdef MEM_TIMEOUT_EN
                    // ack on the timeout edge takes the branch above and wins
                    else if (to_cnt == TO_LAST) begin
                        state   <= S_DONE;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        dr_out  <= 32'd0;
                        to_flag <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
                    to_flag <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_mem_access.sv
// Scoreboard bench for m_mem_access. Stimulus pushes the expected
// {dr_out, exc_code} for each bus access; a monitor pops and compares on
// every done pulse. Stimulus also checks stall length and bus stability.
module tb_m_mem_access;

    logic        clk = 1'b0;
    logic        reset, valid, flush, bus_ack;
    logic [3:0]  mem_op;
    logic [31:0] addr, store_data, bus_rdata;
    logic        bus_req, bus_we, stall, done;
    logic [31:0] bus_addr, bus_wdata, dr_out;
    logic [3:0]  bus_byteen;
    logic [4:0]  exc_code;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] dr;
        logic [4:0]  exc;
    } exp_t;
    exp_t sb[$];

    m_mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .flush(flush),
        .mem_op(mem_op), .addr(addr), .store_data(store_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_byteen(bus_byteen),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stall(stall), .dr_out(dr_out), .done(done), .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest expected response
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending access");
            end else begin
                e = sb.pop_front();
                chk("done_dr_out", dr_out, e.dr);
                chk("done_exc_code", {27'd0, exc_code}, {27'd0, e.exc});
            end
        end
    end

    // One access: ack is raised on REQ cycle (delay+1).
    task automatic do_access(input string nm, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rd, input int delay,
                             input int exp_stall, input int exp_req, input logic [3:0] exp_be,
                             input logic exp_we, input logic chk_wd, input logic [31:0] exp_wd,
                             input logic [31:0] exp_dr, input logic [4:0] exp_exc);
        int  ncyc = 0;
        int  reqcyc = 0;
        bit  fin = 0;
        exp_t e;
        e.dr = exp_dr; e.exc = exp_exc;
        sb.push_back(e);
        @(posedge clk); #1;
        valid = 1'b1; mem_op = op; addr = a; store_data = sd;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!stall) begin fin = 1; break; end
            ncyc++;
            if (bus_req) begin
                reqcyc++;
                chk({nm, "_addr"}, bus_addr, {a[31:2], 2'b00});
                chk({nm, "_byteen"}, {28'd0, bus_byteen}, {28'd0, exp_be});
                chk({nm, "_we"}, {31'd0, bus_we}, {31'd0, exp_we});
                if (chk_wd) chk({nm, "_wdata"}, bus_wdata, exp_wd);
                bus_ack   = (reqcyc > delay);
                bus_rdata = rd;
            end
        end
        bus_ack = 1'b0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL %s_timeout: stall never dropped within 64 cycles", nm);
        end
        chk({nm, "_stall_cycles"}, ncyc, exp_stall);
        chk({nm, "_req_cycles"}, reqcyc, exp_req);
        @(posedge clk); #1;
        valid = 1'b0; mem_op = 4'd0;
    endtask

    task automatic mis(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic fl, input logic [4:0] exp_exc);
        @(posedge clk); #1;
        valid = 1'b1; flush = fl; mem_op = op; addr = a;
        @(negedge clk);
        chk({nm, "_stall"}, {31'd0, stall}, 32'd0);
        chk({nm, "_req"}, {31'd0, bus_req}, 32'd0);
        chk({nm, "_exc"}, {27'd0, exc_code}, {27'd0, exp_exc});
        @(negedge clk);
        chk({nm, "_req2"}, {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0; mem_op = 4'd0;
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; flush = 1'b0; mem_op = 4'd0;
        addr = 32'd0; store_data = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_byteen", {28'd0, bus_byteen}, 32'd0);
        chk("rst_dr_out", dr_out, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;

        // name       op    addr          store_data    rdata        dly stl req be    we chkwd wdata         dr            exc
        do_access("lb",  4'd4, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 2, 1, 4'hF, 0, 0, 32'h0,         32'hFFFF_FF80, 5'd0);
        do_access("sh",  4'd7, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0,        3, 5, 4, 4'hC, 1, 1, 32'hBEEF_BEEF, 32'hFFFF_FF80, 5'd0);
        do_access("lh",  4'd2, 32'h0000_2002, 32'h0,        32'h8001_7FFF, 1, 3, 2, 4'hF, 0, 0, 32'h0,         32'hFFFF_8001, 5'd0);
        do_access("lhu", 4'd3, 32'h0000_2000, 32'h0,        32'h1234_F00D, 0, 2, 1, 4'hF, 0, 0, 32'h0,         32'h0000_F00D, 5'd0);
        do_access("lbu", 4'd5, 32'h0000_2001, 32'h0,        32'hAABB_CCDD, 2, 4, 3, 4'hF, 0, 0, 32'h0,         32'h0000_00CC, 5'd0);
        do_access("lw",  4'd1, 32'h0000_2004, 32'h0,        32'hDEAD_BEEF, 0, 2, 1, 4'hF, 0, 0, 32'h0,         32'hDEAD_BEEF, 5'd0);
        do_access("sb",  4'd8, 32'h0000_2005, 32'h1234_56A5, 32'hFFFF_FFFF, 1, 3, 2, 4'h2, 1, 1, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 5'd0);
        do_access("sw",  4'd6, 32'h0000_2008, 32'h0123_4567, 32'h0,        0, 2, 1, 4'hF, 1, 1, 32'h0123_4567, 32'hDEAD_BEEF, 5'd0);

        mis("lw_mis",  4'd1, 32'h0000_3001, 1'b0, 5'd4);
        mis("sw_mis",  4'd6, 32'h0000_3002, 1'b0, 5'd5);
        mis("lh_mis",  4'd2, 32'h0000_3003, 1'b0, 5'd4);
        mis("sh_mis",  4'd7, 32'h0000_3001, 1'b0, 5'd5);
        mis("lw_misfl", 4'd1, 32'h0000_3001, 1'b1, 5'd0);
        mis("lw_flush", 4'd1, 32'h0000_3000, 1'b1, 5'd0);
        mis("op_none", 4'd12, 32'h0000_3000, 1'b0, 5'd0);

        // LHU enters REQ, flush arrives (ignored), then reset mid-REQ
        @(posedge clk); #1;
        valid = 1'b1; mem_op = 4'd3; addr = 32'h0000_4002;
        @(negedge clk);
        chk("rq_stall_idle", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("rq_req_flush", {31'd0, bus_req}, 32'd1);
        chk("rq_stall_req", {31'd0, stall}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rq_req_async", {31'd0, bus_req}, 32'd0);
        chk("rq_stall_rst", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rq_req_after", {31'd0, bus_req}, 32'd0);
            chk("rq_done_after", {31'd0, done}, 32'd0);
        end
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0; mem_op = 4'd0;

`ifdef MEM_TIMEOUT_EN
        // dr_out was reset above; timeout forces 0 anyway
        do_access("lw_to", 4'd1, 32'h0000_5000, 32'h0, 32'h1111_2222, 99, 5, 4, 4'hF, 0, 0, 32'h0, 32'h0, 5'd7);
        do_access("lw_ack4", 4'd1, 32'h0000_5004, 32'h0, 32'h3333_4444, 3, 5, 4, 4'hF, 0, 0, 32'h0, 32'h3333_4444, 5'd0);
`endif

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m_mem_access.md
# m_mem_access

M-stage data-memory access controller for the pipelined MIPS core. It turns the decoded M-stage load/store into a request/acknowledge transaction on the data bus and stalls the pipeline until the bus answers. It aligns and sign/zero-extends load data and delivers it as the `DR` value that the M/W pipeline register captures. Misaligned accesses are flagged as AdEL/AdES exception codes for CP0.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of cycles spent in REQ without `bus_ack` before the access is abandoned. Used only when `MEM_TIMEOUT_EN` is defined.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `valid`  in  1  M-stage instruction is real (not a bubble).
- `flush`  in  1  exception/eret flush; blocks new accesses.
- `mem_op`  in  4  0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB. Values 9–15 are treated as none.
- `addr`  in  32  effective byte address.
- `store_data`  in  32  rt value.
- `bus_req`  out  1  registered request.
- `bus_we`  out  1  registered; 1 for a store.
- `bus_addr`  out  32  registered; word-aligned (`addr & ~3`).
- `bus_wdata`  out  32  registered; store data replicated into lanes.
- `bus_byteen`  out  4  registered byte enables.
- `bus_ack`  in  1  bus completion, sampled at posedge while `bus_req`=1.
- `bus_rdata`  in  32  read word, valid when `bus_ack`=1.
- `stall`  out  1  combinational; freeze F/D/E/M and hold W.
- `dr_out`  out  32  registered extended load result.
- `done`  out  1  registered; 1-cycle pulse when the access completes.
- `exc_code`  out  5  combinational: 4 AdEL, 5 AdES, 7 bus error, 0 none.

## Operation
- Effective start condition: `start = valid & ~flush & op_is_mem & ~misaligned` (`op_is_mem` = `mem_op` in 1–8).
- Misalignment rules:
  - LW/SW: `addr[1:0]` != 0.
  - LH/LHU/SH: `addr[0]` = 1.
  - Bytes are never misaligned.
- A misaligned access issues no bus request and does not stall. `exc_code` is 4 for a load and 5 for a store whenever `valid & ~flush`.
- FSM states:
  - IDLE → REQ on `start`. Bus outputs are loaded in the same edge.
  - REQ → DONE on `bus_ack`. Loads capture `dr_out`.
  - DONE → IDLE unconditionally.
- `bus_req` = 1 exactly while in REQ. `bus_addr`, `bus_wdata`, `bus_byteen` and `bus_we` hold stable throughout REQ.
- Store byte enables and data:
  - SW: byteen 4'b1111.
  - SH: byteen 4'b0011 << `addr[1:0]`, wdata {2{sd[15:0]}}.
  - SB: byteen 4'b0001 << `addr[1:0]`, wdata {4{sd[7:0]}}.
- Load byteen is 4'b1111. Loads select little-endian lanes by `addr[1:0]` (latched at start):
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Stores leave `dr_out` unchanged.
- `flush` is sampled only in IDLE. An access already in REQ runs to `bus_ack` regardless of `flush`, because the bus cannot be aborted.
- `stall = (IDLE & start) | REQ`. Stall is 0 in DONE, so the pipeline advances and W captures `dr_out` at the DONE→IDLE edge.

## Timing
- Reset values: state IDLE; `bus_req`, `bus_we`, `done` = 0; `bus_addr`, `bus_wdata`, `dr_out` = 0; `bus_byteen` = 0.
- Minimum access cycle by cycle:
  - Edge 0: `start` observed.
  - Edge 1: REQ with `bus_ack`=1.
  - Edge 2: leave DONE.
- Total cost is 2 stall cycles (IDLE-start cycle plus REQ cycle) + N extra wait cycles for each cycle `bus_ack` is late.
- `done` is high during the DONE cycle only.
- `bus_ack` while not in REQ is ignored.
- A back-to-back memory op in M enters REQ on the edge after DONE. There is never a bubble-free overlap.
- Reset asserted mid-REQ drops `bus_req` immediately (asynchronous). No done pulse follows.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears on REQ entry and increments each REQ cycle without ack.
  - On reaching `TIMEOUT_CYCLES`, the FSM goes REQ→DONE with `bus_req` dropped and `dr_out` = 0.
  - `exc_code` = 7 during that DONE cycle.
  - An ack arriving on the same edge as the timeout wins, and the access completes normally.
- `MEM_TIMEOUT_EN` undefined: no counter. REQ waits indefinitely, and `exc_code` never takes value 7.

## Test plan
- LB, `addr`=0x1003, `bus_rdata`=0x80FF_1234, ack on the first REQ cycle → `stall` for 2 cycles, `dr_out`=0xFFFF_FF80, `done` pulses once.
- SH, `addr`=0x2002, `store_data`=0xAAAA_BEEF, ack delayed 3 cycles → `bus_byteen`=4'b1100, `bus_wdata`=0xBEEF_BEEF stable for 4 REQ cycles, `stall` for 5 cycles.
- LW, `addr`=0x3001 → no `bus_req`, `stall`=0, `exc_code`=4. SW, `addr`=0x3002 → `exc_code`=5.
- LHU started, then `flush`=1 and `reset` pulsed in REQ → `bus_req` falls at reset assertion, `done` stays 0, state returns to IDLE.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, LW with no ack → `bus_req` high for 4 cycles, then DONE with `exc_code`=7 and `dr_out`=0. Repeat with ack on cycle 4 → normal completion.
